serial_mag_cmp: RTL

Parametrised serial magnitude comparator. Two operands arrive one bit per qualified clock, MSB first, in words of WIDTH bits. The block reports the running relation after every bit and latches a final per-word result with a one-cycle done pulse. It supersedes the fixed 32-bit, unsigned-only 2-bit-output comparator FSM and adds word framing, a bit qualifier and an optional two's-complement mode.

---
 rtl/serial_mag_cmp_if.sv | 26 ++
 rtl/serial_mag_cmp.sv | 73 +++++++
 2 files changed

// File: rtl/serial_mag_cmp_if.sv
// Bit-serial comparator bus: operand bits, qualifier and sign mode in;
// running relation, final result, done pulse and bit index out.
interface serial_mag_cmp_if #(
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(WIDTH);

  logic          a;
  logic          b;
  logic          bit_en;
  logic          sgn;
  logic [1:0]    y;
  logic [1:0]    result;
  logic          word_done;
  logic [CW-1:0] bit_cnt;

  modport master (
    output a, b, bit_en, sgn,
    input  y, result, word_done, bit_cnt
  );

  modport slave (
    input  a, b, bit_en, sgn,
    output y, result, word_done, bit_cnt
  );
endinterface

// File: rtl/serial_mag_cmp.sv
// Serial MSB-first magnitude comparator with word framing, bit qualifier and
// optional two's-complement handling of the sign bit.
module serial_mag_cmp #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  serial_mag_cmp_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    EQ  = 2'b00,
    AGT = 2'b01,
    BLT = 2'b10
  } state_t;

  state_t        state_reg;
  state_t        state_next;
  state_t        result_reg;
  logic          word_done_reg;
  logic [CW-1:0] bit_cnt_reg;

  logic first_bit;
  logic last_bit;
  logic invert;

  // The mode only changes how the MSB is judged, so it is taken straight
  // from sgn on the MSB edge; later bits always compare unsigned.
  assign first_bit = (bit_cnt_reg == '0);
  assign last_bit  = (bit_cnt_reg == LAST_BIT);
  assign invert    = first_bit & bus.sgn & SIGNED_EN;

  always_comb begin
    state_t base;
    base       = first_bit ? EQ : state_reg;
    state_next = base;
    if (base == EQ) begin
      if (bus.a && !bus.b)
        state_next = invert ? BLT : AGT;
      else if (!bus.a && bus.b)
        state_next = invert ? AGT : BLT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= EQ;
      result_reg    <= EQ;
      word_done_reg <= 1'b0;
      bit_cnt_reg   <= '0;
    end else begin
      word_done_reg <= 1'b0;
      if (bus.bit_en) begin
        state_reg <= state_next;
        if (last_bit) begin
          bit_cnt_reg   <= '0;
          result_reg    <= state_next;
          word_done_reg <= 1'b1;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + CW'(1);
        end
      end
    end
  end

  assign bus.y         = state_reg;
  assign bus.result    = result_reg;
  assign bus.word_done = word_done_reg;
  assign bus.bit_cnt   = bit_cnt_reg;
endmodule
